ps2_host_tx: RTL



---
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  ps2_host_tx : host-to-device PS/2 command transmitter (open-collector pads)
//  Revision    : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_inh_w = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_inh_w-1:0] c_inh_one  = c_inh_w'(1);
    localparam logic [19:0]        c_to_last  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic [3:0]         r_n, w_n_nxt;
    logic [c_inh_w-1:0] r_inh_cnt, w_inh_nxt;
    logic [19:0]        r_to_cnt, w_to_nxt;
    logic               r_nack, w_nack_nxt;
    logic               w_c_oe_nxt, w_d_oe_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

    logic [7:0]         r_c_sr, r_d_sr;
    logic               r_c_filt, r_d_filt;
    logic               w_c_fall, w_par, w_active, w_timeout, w_lines_idle;

    // Pad filters: the level only changes after eight identical samples.
    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            r_c_sr   <= 8'hFF;
            r_d_sr   <= 8'hFF;
            r_c_filt <= 1'b1;
            r_d_filt <= 1'b1;
        end else begin
            r_c_sr <= {r_c_sr[6:0], ps2c_in};
            r_d_sr <= {r_d_sr[6:0], ps2d_in};
            if (r_c_sr == 8'h00)      r_c_filt <= 1'b0;
            else if (r_c_sr == 8'hFF) r_c_filt <= 1'b1;
            if (r_d_sr == 8'h00)      r_d_filt <= 1'b0;
            else if (r_d_sr == 8'hFF) r_d_filt <= 1'b1;
        end
    end

    // Fall strobe coincides with the edge on which the filtered clock drops.
    assign w_c_fall     = r_c_filt & (r_c_sr == 8'h00);
    assign w_par        = ~^r_data;
    assign w_lines_idle = r_c_filt & r_d_filt;
    assign w_active     = (r_state == S_SEND) || (r_state == S_ACK) ||
                          (r_state == S_WAIT_IDLE);
    assign w_timeout    = w_active && !w_c_fall && (r_to_cnt == c_to_last);

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_data    <= 8'h00;
            r_n       <= 4'd0;
            r_inh_cnt <= '0;
            r_to_cnt  <= 20'd0;
            r_nack    <= 1'b0;
            ps2c_oe   <= 1'b0;
            ps2d_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_n       <= w_n_nxt;
            r_inh_cnt <= w_inh_nxt;
            r_to_cnt  <= w_to_nxt;
            r_nack    <= w_nack_nxt;
            ps2c_oe   <= w_c_oe_nxt;
            ps2d_oe   <= w_d_oe_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_n_nxt     = r_n;
        w_inh_nxt   = '0;
        w_to_nxt    = 20'd0;
        w_nack_nxt  = r_nack;
        w_c_oe_nxt  = 1'b0;
        w_d_oe_nxt  = ps2d_oe;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_d_oe_nxt = 1'b0;
                if (tx_start) begin
                    w_data_nxt  = tx_data;
                    w_n_nxt     = 4'd0;
                    w_nack_nxt  = 1'b0;
                    w_c_oe_nxt  = 1'b1;
                    w_state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_c_oe_nxt = 1'b1;
                w_d_oe_nxt = 1'b0;
                w_inh_nxt  = r_inh_cnt + c_inh_one;
                if (r_inh_cnt == c_inh_last) begin
                    w_inh_nxt   = '0;
                    w_d_oe_nxt  = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Release the clock; the start bit stays driven until fall 1.
                w_d_oe_nxt  = 1'b1;
                w_n_nxt     = 4'd0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_to_nxt = r_to_cnt + 20'd1;
                if (w_c_fall) begin
                    w_to_nxt = 20'd0;
                    w_n_nxt  = r_n + 4'd1;
                    if (r_n == 4'd9) begin
                        w_d_oe_nxt  = 1'b0;
                        w_state_nxt = S_ACK;
                    end else if (r_n == 4'd8) begin
                        w_d_oe_nxt = ~w_par;
                    end else begin
                        w_d_oe_nxt = ~r_data[r_n[2:0]];
                    end
                end
            end
            S_ACK: begin
                w_d_oe_nxt = 1'b0;
                w_to_nxt   = r_to_cnt + 20'd1;
                if (w_c_fall) begin
                    w_to_nxt    = 20'd0;
                    w_nack_nxt  = r_d_filt;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_d_oe_nxt = 1'b0;
                w_to_nxt   = w_c_fall ? 20'd0 : r_to_cnt + 20'd1;
                if (w_lines_idle) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_nack;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_d_oe_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // A normal completion in the same cycle takes precedence over timeout.
        if (w_timeout && !((r_state == S_WAIT_IDLE) && w_lines_idle)) begin
            w_c_oe_nxt  = 1'b0;
            w_d_oe_nxt  = 1'b0;
            w_to_nxt    = 20'd0;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

endmodule
`default_nettype wire
